// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: RV64 fetch with PC, imem request channel, redirects and a one-entry skid; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module riscv_fetch_stage #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opc,
  output logic            fetch_fault
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} stateT;
  stateT state, nextState;
  logic [XLEN-1:0] pc, skidPc, target;
  logic [31:0] skidInst;
  logic drop, reqFire, redirect, misalign, respAccept, outFree, holdRelease;
  assign redirect    = branch_taken && state != FAULT;
  assign reqFire     = imem_req_valid && imem_req_ready;
  assign respAccept  = state == WAIT && imem_resp_valid && !drop;
  assign outFree     = !inst_valid || !stall;
  assign holdRelease = state == HOLD && !stall;
  assign opc         = inst[6:0];
`ifdef FETCH_MISALIGN_TRAP_EN
  logic faultReg;
  assign target      = branch_target;
  assign misalign    = redirect && |branch_target[1:0];
  assign fetch_fault = faultReg;
  // sticky trap flag, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) faultReg <= 1'b0;
    else if (misalign) faultReg <= 1'b1;
`else
  assign target      = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= REQ;
    else state <= nextState;
  // next state: redirect beats everything, FAULT is absorbing
  always_comb begin
    nextState = state;
    if (state == FAULT || misalign) nextState = FAULT;
    else if (redirect) nextState = ((state == REQ && reqFire) || (state == WAIT && !imem_resp_valid)) ? WAIT : REQ;
    else nextState = state == REQ  ? (reqFire ? WAIT : REQ) :
                     state == WAIT ? (!imem_resp_valid ? WAIT : (drop || outFree) ? REQ : HOLD) :
                     (stall ? HOLD : REQ);
  end
  // request outputs: no fetch while the presented word is stalled
  always_comb begin
    imem_req_valid = !rst && state == REQ && !(inst_valid && stall);
    imem_req_addr  = pc;
  end
  // pc advances on an accepted response; drop marks an orphaned outstanding request
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc   <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc   <= redirect ? target : respAccept ? pc + XLEN'(4) : pc;
      drop <= redirect ? ((state == REQ && reqFire) || (state == WAIT && !imem_resp_valid)) :
              (state == WAIT && imem_resp_valid) ? 1'b0 : drop;
    end
  // skid captures a response that arrives while the output is stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skidInst <= '0;
      skidPc   <= '0;
    end else if (respAccept && !outFree && !branch_taken) begin
      skidInst <= imem_resp_data;
      skidPc   <= pc;
    end
  // output registers: load from response or skid, clear on consume or redirect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (redirect) inst_valid <= 1'b0;
    else if (respAccept && outFree) begin
      inst_valid <= 1'b1;
      inst       <= imem_resp_data;
      inst_pc    <= pc;
    end else if (holdRelease) begin
      inst_valid <= 1'b1;
      inst       <= skidInst;
      inst_pc    <= skidPc;
    end else if (!stall) inst_valid <= 1'b0;
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: cycle-scripted vectors for the fetch stage plus trap and wrap sequences
module tb_riscv_fetch_stage;
  logic clk = 0, rst = 1;
  logic rdy = 0, rv = 0, bt = 0, st = 0;
  logic [31:0] rd = 0;
  logic [63:0] btg = 0;
  logic reqValid, instValid, fault, reqValid1, instValid1, fault1;
  logic [63:0] reqAddr, instPc, reqAddr1, instPc1;
  logic [31:0] instW, instW1;
  logic [6:0] opc, opc1;
  int errors = 0, checks = 0;
  typedef struct {
    logic rdy, rv; logic [31:0] rd; logic bt; logic [63:0] btg; logic st;
    logic ev; logic [63:0] ea; logic iv; logic [31:0] ii; logic [63:0] ip;
  } vecT;
  vecT v[29];
  always #5 clk = ~clk;
  riscv_fetch_stage u0 (.clk(clk), .rst(rst), .imem_req_valid(reqValid), .imem_req_ready(rdy),
    .imem_req_addr(reqAddr), .imem_resp_valid(rv), .imem_resp_data(rd), .branch_taken(bt),
    .branch_target(btg), .stall(st), .inst_valid(instValid), .inst(instW), .inst_pc(instPc),
    .opc(opc), .fetch_fault(fault));
  riscv_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u1 (.clk(clk), .rst(rst),
    .imem_req_valid(reqValid1), .imem_req_ready(rdy), .imem_req_addr(reqAddr1), .imem_resp_valid(rv),
    .imem_resp_data(rd), .branch_taken(bt), .branch_target(btg), .stall(st), .inst_valid(instValid1),
    .inst(instW1), .inst_pc(instPc1), .opc(opc1), .fetch_fault(fault1));
  function automatic vecT mk(logic r, logic vv, logic [31:0] d, logic b, logic [63:0] t, logic s,
                             logic ev, logic [63:0] ea, logic iv, logic [31:0] ii, logic [63:0] ip);
    vecT x;
    x.rdy = r; x.rv = vv; x.rd = d; x.bt = b; x.btg = t; x.st = s;
    x.ev = ev; x.ea = ea; x.iv = iv; x.ii = ii; x.ip = ip;
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  initial begin
    v[0]  = mk(1, 0, 0,            0, 0,     0, 1, 64'h0,   0, 0,            64'h0);
    v[1]  = mk(1, 1, 32'h33,       0, 0,     0, 0, 64'h0,   0, 0,            64'h0);
    v[2]  = mk(1, 0, 0,            0, 0,     0, 1, 64'h4,   1, 32'h33,       64'h0);
    v[3]  = mk(1, 1, 32'h00100093, 0, 0,     0, 0, 64'h4,   0, 32'h33,       64'h0);
    v[4]  = mk(1, 0, 0,            0, 0,     1, 0, 64'h8,   1, 32'h00100093, 64'h4);
    v[5]  = mk(1, 0, 0,            0, 0,     0, 1, 64'h8,   1, 32'h00100093, 64'h4);
    v[6]  = mk(1, 0, 0,            0, 0,     1, 0, 64'h8,   0, 32'h00100093, 64'h4);
    v[7]  = mk(1, 1, 32'h13,       0, 0,     1, 0, 64'h8,   0, 32'h00100093, 64'h4);
    v[8]  = mk(1, 0, 0,            0, 0,     1, 0, 64'hC,   1, 32'h13,       64'h8);
    v[9]  = mk(1, 0, 0,            0, 0,     1, 0, 64'hC,   1, 32'h13,       64'h8);
    v[10] = mk(1, 0, 0,            0, 0,     0, 1, 64'hC,   1, 32'h13,       64'h8);
    v[11] = mk(1, 0, 0,            1, 'h100, 0, 0, 64'hC,   0, 32'h13,       64'h8);
    v[12] = mk(1, 1, 32'hDEADBEEF, 0, 0,     0, 0, 64'h100, 0, 32'h13,       64'h8);
    v[13] = mk(1, 0, 0,            0, 0,     0, 1, 64'h100, 0, 32'h13,       64'h8);
    v[14] = mk(1, 1, 32'h63,       0, 0,     0, 0, 64'h100, 0, 32'h13,       64'h8);
    v[15] = mk(0, 0, 0,            0, 0,     0, 1, 64'h104, 1, 32'h63,       64'h100);
    for (int i = 16; i <= 20; i++)
      v[i] = mk(0, 0, 0,           0, 0,     0, 1, 64'h104, 0, 32'h63,       64'h100);
    v[21] = mk(1, 0, 0,            1, 'h200, 0, 1, 64'h104, 0, 32'h63,       64'h100);
    v[22] = mk(1, 1, 32'hBAD,      0, 0,     0, 0, 64'h200, 0, 32'h63,       64'h100);
    v[23] = mk(1, 0, 0,            0, 0,     0, 1, 64'h200, 0, 32'h63,       64'h100);
    v[24] = mk(1, 1, 32'h11111111, 1, 'h300, 0, 0, 64'h200, 0, 32'h63,       64'h100);
    v[25] = mk(1, 0, 0,            0, 0,     0, 1, 64'h300, 0, 32'h63,       64'h100);
    v[26] = mk(1, 1, 32'h37,       0, 0,     0, 0, 64'h300, 0, 32'h63,       64'h100);
    v[27] = mk(0, 0, 0,            0, 0,     0, 1, 64'h304, 1, 32'h37,       64'h300);
    v[28] = mk(0, 0, 0,            1, 'h102, 0, 1, 64'h304, 0, 32'h37,       64'h300);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_valid", {63'b0, reqValid}, 0);
    chk("rst inst_valid", {63'b0, instValid}, 0);
    chk("rst inst", {32'b0, instW}, 0);
    chk("rst inst_pc", instPc, 0);
    chk("rst opc", {57'b0, opc}, 0);
    chk("rst fetch_fault", {63'b0, fault}, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 29; i++) begin
      rdy = v[i].rdy; rv = v[i].rv; rd = v[i].rd; bt = v[i].bt; btg = v[i].btg; st = v[i].st;
      @(negedge clk);
      chk($sformatf("c%0d req_valid", i), {63'b0, reqValid}, {63'b0, v[i].ev});
      chk($sformatf("c%0d req_addr", i), reqAddr, v[i].ea);
      chk($sformatf("c%0d inst_valid", i), {63'b0, instValid}, {63'b0, v[i].iv});
      chk($sformatf("c%0d inst", i), {32'b0, instW}, {32'b0, v[i].ii});
      chk($sformatf("c%0d inst_pc", i), instPc, v[i].ip);
      chk($sformatf("c%0d opc", i), {57'b0, opc}, {57'b0, v[i].ii[6:0]});
      chk($sformatf("c%0d fetch_fault", i), {63'b0, fault}, 0);
      if (i == 0) chk("wrap addr0", reqAddr1, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 2) begin
        chk("wrap addr1", reqAddr1, 64'h0);
        chk("wrap inst_pc", instPc1, 64'hFFFF_FFFF_FFFF_FFFC);
      end
      @(posedge clk); #1;
    end
    bt = 0; btg = 0; rdy = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("trap fetch_fault", {63'b0, fault}, 1);
      chk("trap req_valid", {63'b0, reqValid}, 0);
      chk("trap inst_valid", {63'b0, instValid}, 0);
      @(posedge clk); #1;
    end
`else
    @(negedge clk);
    chk("align req_valid", {63'b0, reqValid}, 1);
    chk("align req_addr", reqAddr, 64'h100);
    chk("align fetch_fault", {63'b0, fault}, 0);
`endif
    rst = 1;
    #2;
    chk("rerst fetch_fault", {63'b0, fault}, 0);
    chk("rerst req_valid", {63'b0, reqValid}, 0);
    chk("rerst req_addr", reqAddr, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
